// File: rtl/ef_sram_arbiter.sv
// ============================================================================
// Module  : ef_sram_arbiter
// Purpose : Two-port round-robin arbiter and 3-stage sequencer for one
//           EF_SRAM macro (AD/DI/BEN/EN/R_WB out, DO in).
//           Define EF_SRAM_ARB_FIXED_PRIO_EN for strict port-0 priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ef_sram_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          UserCLK,
  input  logic          RESET_N,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [DW-1:0] req0_ben,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [DW-1:0] req1_ben,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          sram_en,
  output logic          sram_r_wb,
  output logic [AW-1:0] sram_ad,
  output logic [DW-1:0] sram_di,
  output logic [DW-1:0] sram_ben,
  input  logic [DW-1:0] sram_do
);

  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_ben;
  logic [DW-1:0] w_rdata;

  logic          r_s1_port;
  logic          r_s1_we;
  logic          r_s2_valid;
  logic          r_s2_port;
  logic          r_s2_we;

`ifdef EF_SRAM_ARB_FIXED_PRIO_EN
  assign w_grant0 = RESET_N & req0_valid;
  assign w_grant1 = RESET_N & req1_valid & ~req0_valid;
`else
  logic r_last_grant;

  // On contention the port that did not win last time is served.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (RESET_N) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end
`endif

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_accept   = w_grant0 | w_grant1;

  assign w_we    = w_grant1 ? req1_we    : req0_we;
  assign w_addr  = w_grant1 ? req1_addr  : req0_addr;
  assign w_wdata = w_grant1 ? req1_wdata : req0_wdata;
  assign w_ben   = w_grant1 ? req1_ben   : req0_ben;

  // Issue stage: macro pins are parked at zero / read when idle.
  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sram_en   <= 1'b0;
      sram_r_wb <= 1'b1;
      sram_ad   <= '0;
      sram_di   <= '0;
      sram_ben  <= '0;
      r_s1_port <= 1'b0;
      r_s1_we   <= 1'b0;
    end else begin
      sram_en   <= w_accept;
      sram_r_wb <= ~(w_accept & w_we);
      sram_ad   <= w_accept ? w_addr : '0;
      sram_di   <= (w_accept && w_we) ? w_wdata : '0;
      sram_ben  <= (w_accept && w_we) ? w_ben : '0;
      r_s1_port <= w_accept & w_grant1;
      r_s1_we   <= w_accept & w_we;
    end
  end

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s2_valid <= 1'b0;
      r_s2_port  <= 1'b0;
      r_s2_we    <= 1'b0;
    end else begin
      r_s2_valid <= sram_en;
      r_s2_port  <= r_s1_port;
      r_s2_we    <= r_s1_we;
    end
  end

  assign w_rdata = (r_s2_valid && !r_s2_we) ? sram_do : '0;

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= r_s2_valid & ~r_s2_port;
      rsp1_valid <= r_s2_valid & r_s2_port;
      rsp0_rdata <= r_s2_port ? '0 : w_rdata;
      rsp1_rdata <= r_s2_port ? w_rdata : '0;
    end
  end

endmodule

`default_nettype wire
